// File: rtl/chain_dp_max.sv
// Chaining DP step: f(i) = max(W_i, max_k sat32(f(i-k) + score(i,k))) over a sliding
// history window, with one header, npred score beats and one result per anchor.
module chain_dp_max #(
    parameter int DEPTH = 64,
    parameter int IDXW  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     a_valid,
    output logic                     a_ready,
    input  logic [31:0]              a_w,
    input  logic [$clog2(DEPTH):0]   a_npred,
    input  logic                     a_clr,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [31:0]              s_score,
    input  logic                     s_ok,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [31:0]              m_f,
    output logic [IDXW-1:0]          m_p,
    output logic [IDXW-1:0]          m_idx
);
    localparam int AW  = $clog2(DEPTH);
    localparam int NPW = AW + 1;
    localparam int CW  = (IDXW > NPW) ? IDXW : NPW;

    typedef enum logic [1:0] {IDLE, ACC, EMIT} state_t;

    state_t                 state, state_nxt;
    logic [IDXW-1:0]        i;
    logic [NPW-1:0]         k;
    logic [NPW-1:0]         cnt;
    logic signed [31:0]     best;
    logic [IDXW-1:0]        bestp;
    logic signed [31:0]     hist [DEPTH];

    logic                   hdr_fire, beat_fire, out_fire;
    logic [NPW-1:0]         npred_eff;
    logic [AW-1:0]          j;
    logic signed [31:0]     hist_rd;
    logic signed [32:0]     sum;
    logic signed [31:0]     cand;
    logic                   k_le_i;
    logic                   take;
    logic                   last_beat;

    assign hdr_fire  = a_valid && a_ready;
    assign beat_fire = s_valid && s_ready;
    assign out_fire  = m_valid && m_ready;

    assign npred_eff = (a_npred > NPW'(DEPTH)) ? NPW'(DEPTH) : a_npred;
    assign j         = i[AW-1:0] - k[AW-1:0];
    assign hist_rd   = hist[j];
    assign sum       = {hist_rd[31], hist_rd} + $signed({s_score[31], s_score});

    // Overflow when the two top bits of the 33-bit sum disagree; clamp toward the sign.
    always_comb begin
        cand = sum[31:0];
        if (sum[32] != sum[31])
            cand = sum[32] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
    end

    assign k_le_i    = CW'(k) <= CW'(i);
    assign take      = s_ok && k_le_i && (cand > best);
    assign last_beat = (k == cnt);

    always_comb begin
        state_nxt = state;
        a_ready   = 1'b0;
        s_ready   = 1'b0;
        m_valid   = 1'b0;
        case (state)
            IDLE: begin
                a_ready = !rst;
                if (hdr_fire)
                    state_nxt = (npred_eff == '0) ? EMIT : ACC;
            end
            ACC: begin
                s_ready = 1'b1;
                if (beat_fire && last_beat)
                    state_nxt = EMIT;
            end
            EMIT: begin
                m_valid = 1'b1;
                if (m_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            i     <= '0;
            k     <= '0;
            cnt   <= '0;
            best  <= '0;
            bestp <= '1;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (hdr_fire) begin
                    best  <= $signed(a_w);
                    bestp <= '1;
                    cnt   <= npred_eff;
                    k     <= NPW'(1);
                    if (a_clr)
                        i <= '0;
                end
                ACC: if (beat_fire) begin
                    if (take) begin
                        best  <= cand;
                        bestp <= i - IDXW'(k);
                    end
                    k <= k + NPW'(1);
                end
                EMIT: if (m_ready)
                    i <= i + IDXW'(1);
                default: ;
            endcase
        end
    end

    // History is deliberately not reset; the k<=i mask hides stale entries.
    always_ff @(posedge clk) begin
        if (!rst && out_fire)
            hist[i[AW-1:0]] <= best;
    end

    assign m_f   = best;
    assign m_p   = bestp;
    assign m_idx = i;
endmodule

// File: tb/tb_chain_dp_max.sv
// Bench for chain_dp_max: directed vector table, hand-written reset/backpressure/cap
// sequences, then randomized anchors against a reference model of the chaining rule.
module tb_chain_dp_max;
    localparam int DEPTH = 64;
    localparam int IDXW  = 16;
    localparam int NPW   = $clog2(DEPTH) + 1;

    logic              clk = 0;
    logic              rst;
    logic              a_valid, a_ready, a_clr;
    logic [31:0]       a_w;
    logic [NPW-1:0]    a_npred;
    logic              s_valid, s_ready, s_ok;
    logic [31:0]       s_score;
    logic              m_valid, m_ready;
    logic [31:0]       m_f;
    logic [IDXW-1:0]   m_p, m_idx;

    chain_dp_max #(.DEPTH(DEPTH), .IDXW(IDXW)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_w(a_w), .a_npred(a_npred), .a_clr(a_clr),
        .s_valid(s_valid), .s_ready(s_ready), .s_score(s_score), .s_ok(s_ok),
        .m_valid(m_valid), .m_ready(m_ready), .m_f(m_f), .m_p(m_p), .m_idx(m_idx)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit lost   = 0;

    logic [31:0]        sc  [DEPTH];
    bit                 okv [DEPTH];
    logic signed [31:0] mf  [int];
    int                 mi  = 0;

    typedef struct {
        logic [31:0] w;
        bit          clr;
        int          nb;
        logic [31:0] s0, s1, s2;
        bit          o0, o1, o2;
        logic [31:0] f;
        logic [15:0] p;
        logic [15:0] idx;
    } vec_t;

    vec_t tbl [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic longint sat32(input longint v);
        if (v > 64'sd2147483647)  return 64'sd2147483647;
        if (v < -64'sd2147483648) return -64'sd2147483648;
        return v;
    endfunction

    // Reference: best over legal predecessors, strict improvement keeps the nearer one.
    task automatic model_eval(input logic [31:0] w, input bit clr, input int nb,
                              output logic [31:0] f, output logic [15:0] p, output logic [15:0] idx);
        longint best, c;
        if (clr) mi = 0;
        best = longint'($signed(w));
        p    = 16'hFFFF;
        for (int kk = 1; kk <= nb; kk++) begin
            if (okv[kk-1] && kk <= mi) begin
                c = sat32(longint'(mf[mi-kk]) + longint'($signed(sc[kk-1])));
                if (c > best) begin
                    best = c;
                    p    = 16'(mi - kk);
                end
            end
        end
        f   = 32'(best);
        idx = 16'(mi);
    endtask

    task automatic recover();
        rst = 1; a_valid = 0; s_valid = 0; m_ready = 0;
        tick();
        rst = 0;
        mi = 0;
        lost = 0;
        #1;
    endtask

    task automatic run_anchor(input logic [31:0] w, input bit clr, input int hdr_n, input int nb,
                              input int hold, input bit gaps, input bit use_exp,
                              input logic [31:0] ef, input logic [15:0] ep, input logic [15:0] eidx);
        logic [31:0] xf, mfv;
        logic [15:0] xp, xi;
        int t;
        model_eval(w, clr, nb, mfv, xp, xi);
        xf = mfv;
        if (use_exp) begin xf = ef; xp = ep; xi = eidx; end

        t = 0;
        while (!a_ready && t < 40) begin tick(); t++; end
        if (!a_ready) begin
            chk("hdr_timeout", a_ready, 1);
            recover();
            return;
        end
        a_valid = 1; a_w = w; a_npred = NPW'(hdr_n); a_clr = clr;
        tick();
        a_valid = 0; a_clr = 0;
        if (nb > 0) chk("busy_mvalid", m_valid, 0);

        for (int b = 0; b < nb && !lost; b++) begin
            if (gaps && ($urandom_range(0, 3) == 0)) begin
                s_valid = 0;
                repeat ($urandom_range(1, 2)) tick();
            end
            s_valid = 1; s_score = sc[b]; s_ok = okv[b];
            t = 0;
            while (!s_ready && t < 40) begin tick(); t++; end
            if (!s_ready) lost = 1;
            else tick();
            s_valid = 0;
        end
        if (lost) begin
            chk("beat_timeout", s_ready, 1);
            recover();
            return;
        end

        chk("latency_mvalid", m_valid, 1);
        for (int h = 0; h < hold; h++) begin
            chk("hold_f", m_f, xf);
            chk("hold_a_ready", a_ready, 0);
            tick();
        end
        chk("m_f", m_f, xf);
        chk("m_p", m_p, xp);
        chk("m_idx", m_idx, xi);
        m_ready = 1;
        tick();
        m_ready = 0;
        mf[mi] = $signed(mfv);
        mi = (mi + 1) & 16'hFFFF;
    endtask

    function automatic vec_t mkv(input logic [31:0] w, input bit clr, input int nb,
                                 input logic [31:0] s0, input logic [31:0] s1, input logic [31:0] s2,
                                 input bit o0, input bit o1, input bit o2,
                                 input logic [31:0] f, input logic [15:0] p, input logic [15:0] idx);
        vec_t v;
        v.w = w; v.clr = clr; v.nb = nb;
        v.s0 = s0; v.s1 = s1; v.s2 = s2;
        v.o0 = o0; v.o1 = o1; v.o2 = o2;
        v.f = f; v.p = p; v.idx = idx;
        return v;
    endfunction

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 7))
            0:       return 32'h7FFF_FFF0 - 32'($urandom_range(0, 40));
            1:       return 32'h8000_0010 + 32'($urandom_range(0, 40));
            default: return 32'($signed($urandom_range(0, 40)) - 20);
        endcase
    endfunction

    initial begin
        logic [31:0] snap_f;
        tbl[0] = mkv(32'd15, 1, 0, 0, 0, 0, 0, 0, 0, 32'd15, 16'hFFFF, 16'd0);
        tbl[1] = mkv(32'd15, 0, 1, 32'd12, 0, 0, 1, 0, 0, 32'd27, 16'd0, 16'd1);
        tbl[2] = mkv(32'd15, 0, 3, 32'd3, 32'd15, 32'd999, 1, 1, 0, 32'd30, 16'd1, 16'd2);
        tbl[3] = mkv(32'd5, 1, 3, 32'd100, 32'd100, 32'd100, 1, 1, 1, 32'd5, 16'hFFFF, 16'd0);
        tbl[4] = mkv(32'h7FFF_FFF0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h7FFF_FFF0, 16'hFFFF, 16'd0);
        tbl[5] = mkv(32'd0, 0, 1, 32'd100, 0, 0, 1, 0, 0, 32'h7FFF_FFFF, 16'd0, 16'd1);
        tbl[6] = mkv(32'h8000_0010, 1, 0, 0, 0, 0, 0, 0, 0, 32'h8000_0010, 16'hFFFF, 16'd0);
        tbl[7] = mkv(32'hFFFF_FFFB, 0, 1, 32'hFFFF_FF9C, 0, 0, 1, 0, 0, 32'hFFFF_FFFB, 16'hFFFF, 16'd1);

        rst = 1; a_valid = 0; a_w = 0; a_npred = 0; a_clr = 0;
        s_valid = 0; s_score = 0; s_ok = 0; m_ready = 0;
        repeat (3) tick();
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_f", m_f, 0);
        chk("rst_m_p", m_p, 16'hFFFF);
        chk("rst_m_idx", m_idx, 0);
        chk("rst_s_ready", s_ready, 0);
        rst = 0;
        #1;
        chk("post_rst_a_ready", a_ready, 1);

        for (int v = 0; v < 8; v++) begin
            sc[0] = tbl[v].s0; sc[1] = tbl[v].s1; sc[2] = tbl[v].s2;
            okv[0] = tbl[v].o0; okv[1] = tbl[v].o1; okv[2] = tbl[v].o2;
            run_anchor(tbl[v].w, tbl[v].clr, tbl[v].nb, tbl[v].nb, 0, 0, 1,
                       tbl[v].f, tbl[v].p, tbl[v].idx);
        end

        // npred above DEPTH is capped: result must follow the DEPTH-th beat directly.
        run_anchor(32'd1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int b = 0; b < DEPTH; b++) begin sc[b] = rnd_val(); okv[b] = 1; end
        run_anchor(32'd0, 0, DEPTH + 6, DEPTH, 0, 0, 0, 0, 0, 0);

        // Output backpressure: values held, header channel blocked.
        run_anchor(32'd7, 0, 0, 0, 10, 0, 0, 0, 0, 0);

        // Reset mid-accumulation abandons the anchor.
        a_valid = 1; a_w = 32'd9; a_npred = 3; a_clr = 0;
        tick();
        a_valid = 0;
        s_valid = 1; s_score = 32'd50; s_ok = 1;
        tick();
        s_valid = 0;
        rst = 1;
        tick();
        chk("rst_acc_m_valid", m_valid, 0);
        chk("rst_acc_m_idx", m_idx, 0);
        chk("rst_acc_s_ready", s_ready, 0);
        rst = 0;
        #1;
        chk("rst_acc_a_ready", a_ready, 1);
        mi = 0;

        // Reset while a result is pending: no transfer, index stays 0.
        a_valid = 1; a_w = 32'd3; a_npred = 0;
        tick();
        a_valid = 0;
        chk("rst_emit_pre_valid", m_valid, 1);
        snap_f = m_f;
        chk("rst_emit_pre_f", snap_f, 32'd3);
        rst = 1;
        tick();
        rst = 0;
        #1;
        chk("rst_emit_m_valid", m_valid, 0);
        chk("rst_emit_m_idx", m_idx, 0);

        for (int n = 0; n < 150; n++) begin
            int nb, hn;
            nb = ($urandom_range(0, 15) == 0) ? $urandom_range(9, DEPTH) : $urandom_range(0, 8);
            hn = (nb == DEPTH) ? $urandom_range(DEPTH, 2 * DEPTH - 1) : nb;
            for (int b = 0; b < nb; b++) begin
                sc[b]  = rnd_val();
                okv[b] = ($urandom_range(0, 4) != 0);
            end
            run_anchor(rnd_val(), ($urandom_range(0, 19) == 0), hn, nb,
                       $urandom_range(0, 2), 1, 0, 0, 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/chain_dp_max.md
CHAIN_DP_MAX -- requirements
Module: chain_dp_max

Interface
REQ-001 The module SHALL have parameter DEPTH, default 64, meaning predecessor window size and f-history entries (power of two, 2..256).
REQ-002 The module SHALL have parameter IDXW, default 16, meaning anchor index width.
REQ-003 The module SHALL use one clock and a synchronous, active-high reset, with ports clk and rst.
REQ-004 Port list, in order:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- a_valid  in  1  anchor header valid
- a_ready  out  1  anchor header ready
- a_w  in  32  anchor self score W, signed
- a_npred  in  log2(DEPTH)+1  predecessor beats to follow, 0..DEPTH
- a_clr  in  1  start of new read; anchor index restarts at 0
- s_valid  in  1  score beat valid
- s_ready  out  1  score beat ready
- s_score  in  32  signed score(i,k) from computeScore, k-th nearest predecessor
- s_ok  in  1  candidate legal; 0 = skip beat
- m_valid  out  1  result valid
- m_ready  in  1  result ready
- m_f  out  32  signed chain score f(i)
- m_p  out  IDXW  best predecessor index, all-ones = none
- m_idx  out  IDXW  anchor index i

Function
REQ-005 A transfer SHALL occur on any channel when its valid and ready are both high at a rising clk edge.
REQ-006 The FSM SHALL have three states: IDLE, ACC and EMIT.
- IDLE: a_ready=1, s_ready=0, m_valid=0.
- ACC: s_ready=1, a_ready=0, m_valid=0.
- EMIT: m_valid=1, a_ready=0, s_ready=0.
REQ-007 On header transfer in IDLE, the block SHALL:
- latch a_w as best=a_w, bestp=all-ones, cnt=a_npred, k=1;
- if a_clr=1, set i=0 before use;
- go to ACC if a_npred>0, else go to EMIT.
REQ-008 Each score beat transferred in ACC SHALL use predecessor j=i-k and cand=sat32(hist[j mod DEPTH]+s_score).
REQ-009 cand SHALL replace best only if s_ok=1, k<=i and cand>best (strict); on ties the nearer predecessor SHALL be kept.
REQ-010 The k<=i rule SHALL apply to i as stored, never to a wrapped index; beats with k>i SHALL be consumed and ignored.
REQ-011 On replacement, bestp SHALL be set to i-k, modulo 2^IDXW.
REQ-012 After each beat k SHALL increment; when beat k==cnt transfers, the FSM SHALL go to EMIT on the next cycle.
REQ-013 The first m_valid SHALL assert exactly 1 cycle after the last beat, or after the header when npred=0.
REQ-014 In EMIT, m_f=best, m_p=bestp and m_idx=i SHALL hold stable until m_ready.
REQ-015 On the output transfer, the block SHALL write hist[i mod DEPTH]=best, increment i (wraps to 0 at 2^IDXW), and return to IDLE.
REQ-016 sat32 SHALL clamp to +2147483647 / -2147483648 and SHALL never wrap.
REQ-017 hist reads SHALL be combinational (register array), with no added latency; the same-cycle write in EMIT and read in ACC cannot collide, because the states are exclusive.
REQ-018 a_npred>DEPTH SHALL be treated as DEPTH; the excess beats are not expected upstream.
REQ-019 Inputs on a channel whose ready is low SHALL be ignored.
REQ-020 Throughput SHALL be one anchor per npred+2 cycles under no backpressure.

Reset
REQ-021 With rst=1 at a clk edge, the block SHALL enter IDLE, set i=0, k=0, cnt=0, best=0 and bestp=all-ones.
REQ-022 During reset, outputs SHALL read m_valid=0, m_f=0, m_p=all-ones, m_idx=0, s_ready=0; a_ready=1 from the first cycle after rst deasserts.
REQ-023 hist contents SHALL NOT be cleared; a clean read is guaranteed only because k<=i masks stale entries.
REQ-024 Reset mid-ACC or mid-EMIT SHALL abandon the anchor with no output transfer and no hist write.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- First anchor: a_clr=1, a_w=15, npred=0 -> m_valid 1 cycle later, m_f=15, m_p=0xFFFF, m_idx=0.
- Chain: anchors 0,1 with w=15 and npred 0,1; anchor 1 beat score=12, ok=1 -> m_f=27, m_p=0, m_idx=1.
- Tie/skip: at i=2, hist f0=15, f1=27; beats k=1 score=3 (cand 30), k=2 score=15 (cand 30), then a third beat ok=0 score=999 -> m_f=30, m_p=1.
- Masking: a_clr=1, a_w=5, npred=3, scores 100 each -> m_f=5, m_p=0xFFFF (k>i).
- Saturation: hist f=0x7FFFFFF0, score=+100 -> m_f=0x7FFFFFFF; negative all-beats case keeps a_w.
- Backpressure/reset: hold m_ready=0 10 cycles -> outputs stable, a_ready=0; assert rst in ACC -> next cycle IDLE, m_valid=0, i=0.
